spu_adsr_sequencer: RTL and testbench

Time-multiplexed ADSR envelope sequencer for the SPU voice engine. On every sample tick it walks all voices in order. For each voice it:
- looks up the active phase's rate in the external rate-table ROM (7-bit address, 15-bit signed output, 1-cycle registered read),
- advances a per-voice rate accumulator and the envelope level,
- emits the new level to the voice mixer.

It owns the per-voice ADSR configuration, phase, level and accumulator state.

---
 rtl/spu_adsr_pkg.sv | 34 +++
 rtl/spu_adsr_step.sv | 75 +++++++
 rtl/spu_adsr_sequencer.sv | 166 ++++++++++++++++
 tb/tb_spu_adsr_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_adsr_pkg.sv
// Shared types and constants for the SPU ADSR envelope sequencer.
// Optional voice-end flags are enabled with SPU_ADSR_ENDX_EN (see spu_adsr_sequencer).
package spu_adsr_pkg;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  typedef struct packed {
    phase_e      ph;
    logic [14:0] lvl;
    logic [14:0] acc;
  } voice_t;

  // ADSR word layout: [31:25] AR, [24:18] DR, [17:14] SL, [13:7] SR, [6:0] RR
  localparam int RATE_W = 7;
  localparam int AR_LSB = 25;
  localparam int DR_LSB = 18;
  localparam int SL_LSB = 14;
  localparam int SR_LSB = 7;
  localparam int RR_LSB = 0;

  localparam logic [14:0] LEVEL_MAX = 15'h7FFF;
  localparam logic [15:0] RATE_ONE  = 16'd16384;

  function automatic logic [14:0] sl_to_slv(input logic [3:0] sl);
    return {sl, 11'h7FF};
  endfunction

endpackage

// File: rtl/spu_adsr_step.sv
// Combinational per-voice envelope step: rate accumulation plus phase/level update.
module spu_adsr_step
  import spu_adsr_pkg::*;
#(
  parameter int STEP = 32
) (
  input  phase_e      phase_i,
  input  logic [14:0] level_i,
  input  logic [14:0] acc_i,
  input  logic [14:0] w_i,
  input  logic [14:0] slv_i,
  output phase_e      phase_o,
  output logic [14:0] level_o,
  output logic [14:0] acc_o,
  output logic        end_o
);

  logic [15:0] a;
  logic [15:0] up;
  logic [14:0] dn;
  logic [14:0] acc_n;
  logic        ev;

  always_comb begin
    a     = {1'b0, acc_i} + {1'b0, w_i};
    ev    = (a >= RATE_ONE);
    acc_n = ev ? 15'(a - RATE_ONE) : a[14:0];
    up    = {1'b0, level_i} + 16'(STEP);
    dn    = (level_i >= 15'(STEP)) ? level_i - 15'(STEP) : '0;

    phase_o = phase_i;
    level_o = level_i;
    acc_o   = acc_n;
    end_o   = 1'b0;

    case (phase_i)
      PH_OFF: begin
        level_o = '0;
        acc_o   = acc_i;
      end
      PH_ATTACK: if (ev) begin
        if (up >= {1'b0, LEVEL_MAX}) begin
          level_o = LEVEL_MAX;
          phase_o = PH_DECAY;
        end else begin
          level_o = up[14:0];
        end
      end
      PH_DECAY: if (ev) begin
        // dn <= SLV means max(dn, SLV) is SLV itself
        if (dn <= slv_i) begin
          level_o = slv_i;
          phase_o = PH_SUSTAIN;
        end else begin
          level_o = dn;
        end
      end
      PH_SUSTAIN: if (ev) level_o = dn;
      PH_RELEASE: if (ev) begin
        level_o = dn;
        if (dn == '0) begin
          phase_o = PH_OFF;
          acc_o   = '0;
          end_o   = 1'b1;
        end
      end
      default: begin
        phase_o = PH_OFF;
        level_o = '0;
        acc_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/spu_adsr_sequencer.sv
// Time-multiplexed ADSR sequencer: one FETCH/CALC pair per voice on each tick.
// Define SPU_ADSR_ENDX_EN to add the per-voice voice_end flags.
module spu_adsr_sequencer
  import spu_adsr_pkg::*;
#(
  parameter int NV   = 24,
  parameter int STEP = 32
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          tick,
  input  logic [NV-1:0] key_on,
  input  logic [NV-1:0] key_off,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_voice,
  input  logic [31:0]   cfg_data,
  output logic          rom_read,
  output logic [6:0]    rom_adrs,
  input  logic [14:0]   rom_dout,
  output logic          env_valid,
  output logic [4:0]    env_voice,
  output logic [14:0]   env_level,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun
`ifdef SPU_ADSR_ENDX_EN
  ,
  output logic [NV-1:0] voice_end
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    st_q, st_d;
  logic [4:0]    v_q, v_d;
  voice_t        vs_q  [NV];
  logic [31:0]   cfg_q [NV];
  logic [NV-1:0] pon_q, pon_d, poff_q, poff_d, vsel;
  logic          snap_on_q, snap_off_q, overrun_q;
  logic [3:0]    snap_sl_q;

  voice_t        cur, stp, nxt;
  logic [31:0]   ccfg;
  phase_e        calc_ph;
  logic [14:0]   w;
  logic          stp_end, fetch, calc;

  assign fetch = (st_q == S_FETCH);
  assign calc  = (st_q == S_CALC);
  assign vsel  = NV'(1) << v_q;
  assign cur   = vs_q[v_q];
  assign ccfg  = cfg_q[v_q];

  // Rate index for the phase CALC will actually run, including a pending key_off
  always_comb begin
    rom_adrs = '0;
    if (fetch && !pon_q[v_q] && cur.ph != PH_OFF) begin
      if (poff_q[v_q]) rom_adrs = ccfg[RR_LSB +: RATE_W];
      else begin
        case (cur.ph)
          PH_ATTACK:  rom_adrs = ccfg[AR_LSB +: RATE_W];
          PH_DECAY:   rom_adrs = ccfg[DR_LSB +: RATE_W];
          PH_SUSTAIN: rom_adrs = ccfg[SR_LSB +: RATE_W];
          PH_RELEASE: rom_adrs = ccfg[RR_LSB +: RATE_W];
          default:    rom_adrs = '0;
        endcase
      end
    end
  end

  assign calc_ph = (snap_off_q && cur.ph != PH_OFF) ? PH_RELEASE : cur.ph;
  assign w       = ~rom_dout + 15'd1;

  spu_adsr_step #(.STEP(STEP)) u_step (
    .phase_i (calc_ph),
    .level_i (cur.lvl),
    .acc_i   (cur.acc),
    .w_i     (w),
    .slv_i   (sl_to_slv(snap_sl_q)),
    .phase_o (stp.ph),
    .level_o (stp.lvl),
    .acc_o   (stp.acc),
    .end_o   (stp_end)
  );

  assign nxt = snap_on_q ? '{ph: PH_ATTACK, lvl: '0, acc: '0} : stp;

  always_comb begin
    st_d = st_q;
    v_d  = v_q;
    case (st_q)
      S_IDLE: if (tick) begin
        st_d = S_FETCH;
        v_d  = '0;
      end
      S_FETCH: st_d = S_CALC;
      S_CALC: begin
        if (v_q == 5'(NV - 1)) st_d = S_DONE;
        else begin
          st_d = S_FETCH;
          v_d  = v_q + 5'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign pon_d  = (pon_q  & ~(vsel & {NV{calc && snap_on_q}})) | key_on;
  assign poff_d = (poff_q & ~(vsel & {NV{calc && (snap_on_q || snap_off_q)}})) | key_off;

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      st_q       <= S_IDLE;
      v_q        <= '0;
      pon_q      <= '0;
      poff_q     <= '0;
      snap_on_q  <= 1'b0;
      snap_off_q <= 1'b0;
      snap_sl_q  <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NV; i++) begin
        vs_q[i]  <= '{ph: PH_OFF, lvl: '0, acc: '0};
        cfg_q[i] <= '0;
      end
    end else begin
      st_q      <= st_d;
      v_q       <= v_d;
      pon_q     <= pon_d;
      poff_q    <= poff_d;
      // A tick in DONE is dropped as well, so it is flagged too
      overrun_q <= overrun_q | (tick && st_q != S_IDLE);
      // Freeze key/SL state at FETCH so CALC matches the ROM address issued
      if (fetch) begin
        snap_on_q  <= pon_q[v_q];
        snap_off_q <= poff_q[v_q];
        snap_sl_q  <= ccfg[SL_LSB +: 4];
      end
      if (calc) vs_q[v_q] <= nxt;
      if (cfg_we && 32'(cfg_voice) < NV) cfg_q[cfg_voice] <= cfg_data;
    end
  end

  assign rom_read   = fetch;
  assign env_valid  = calc;
  assign env_voice  = calc ? v_q : '0;
  assign env_level  = calc ? nxt.lvl : '0;
  assign frame_done = (st_q == S_DONE);
  assign busy       = fetch || calc;
  assign overrun    = overrun_q;

`ifdef SPU_ADSR_ENDX_EN
  logic [NV-1:0] vend_q;
  always_ff @(posedge m_clock) begin
    if (!p_reset) vend_q <= '0;
    else vend_q <= (vend_q & ~key_on) | (vsel & {NV{calc && stp_end && !snap_on_q}});
  end
  assign voice_end = vend_q;
`else
  logic unused_end;
  assign unused_end = stp_end;
`endif

endmodule

// File: tb/tb_spu_adsr_sequencer.sv
// Scoreboard bench for spu_adsr_sequencer; independent behavioural envelope model.
module tb_spu_adsr_sequencer;

  localparam int NV = 24;
  localparam int P_OFF = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic          m_clock = 1'b0;
  logic          p_reset, tick, cfg_we;
  logic [NV-1:0] key_on, key_off;
  logic [4:0]    cfg_voice;
  logic [31:0]   cfg_data;
  logic          rom_read;
  logic [6:0]    rom_adrs;
  logic [14:0]   rom_dout = '0;
  logic          env_valid, frame_done, busy, overrun;
  logic [4:0]    env_voice;
  logic [14:0]   env_level;
`ifdef SPU_ADSR_ENDX_EN
  logic [NV-1:0] voice_end;
`endif

  spu_adsr_sequencer #(.NV(NV), .STEP(32)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .tick(tick),
    .key_on(key_on), .key_off(key_off),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_data(cfg_data),
    .rom_read(rom_read), .rom_adrs(rom_adrs), .rom_dout(rom_dout),
    .env_valid(env_valid), .env_voice(env_voice), .env_level(env_level),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
`ifdef SPU_ADSR_ENDX_EN
    , .voice_end(voice_end)
`endif
  );

  always #5 m_clock = ~m_clock;

  // Rate ROM: index k gives -(16384 >> (k/4)), registered read
  always @(posedge m_clock)
    if (rom_read) rom_dout <= 15'(-(16384 >> (int'(rom_adrs) >> 2)));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model state
  int          m_ph[NV], m_lvl[NV], m_acc[NV];
  bit          m_pon[NV], m_poff[NV], m_end[NV];
  logic [31:0] m_cfg[NV];

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_ph[i] = P_OFF; m_lvl[i] = 0; m_acc[i] = 0;
      m_pon[i] = 0; m_poff[i] = 0; m_end[i] = 0; m_cfg[i] = '0;
    end
  endtask

  task automatic model_voice(input int v, output int lvl);
    int rate, a, slv;
    rate = 0;
    if (m_pon[v]) begin
      m_pon[v] = 0; m_poff[v] = 0;
      m_ph[v] = P_ATK; m_lvl[v] = 0; m_acc[v] = 0;
    end else begin
      if (m_poff[v]) begin
        m_poff[v] = 0;
        if (m_ph[v] != P_OFF) m_ph[v] = P_REL;
      end
      case (m_ph[v])
        P_ATK:   rate = int'((m_cfg[v] >> 25) & 32'h7F);
        P_DEC:   rate = int'((m_cfg[v] >> 18) & 32'h7F);
        P_SUS:   rate = int'((m_cfg[v] >> 7) & 32'h7F);
        P_REL:   rate = int'(m_cfg[v] & 32'h7F);
        default: rate = 0;
      endcase
      if (m_ph[v] == P_OFF) m_lvl[v] = 0;
      else begin
        a = m_acc[v] + (16384 >> (rate >> 2));
        m_acc[v] = (a >= 16384) ? a - 16384 : a;
        if (a >= 16384) begin
          case (m_ph[v])
            P_ATK: begin
              m_lvl[v] += 32;
              if (m_lvl[v] >= 32767) begin m_lvl[v] = 32767; m_ph[v] = P_DEC; end
            end
            P_DEC: begin
              m_lvl[v] = (m_lvl[v] < 32) ? 0 : m_lvl[v] - 32;
              slv = int'((m_cfg[v] >> 14) & 32'hF) * 2048 + 2047;
              if (m_lvl[v] <= slv) begin m_lvl[v] = slv; m_ph[v] = P_SUS; end
            end
            P_SUS: m_lvl[v] = (m_lvl[v] < 32) ? 0 : m_lvl[v] - 32;
            default: begin
              m_lvl[v] = (m_lvl[v] < 32) ? 0 : m_lvl[v] - 32;
              if (m_lvl[v] == 0) begin m_ph[v] = P_OFF; m_acc[v] = 0; m_end[v] = 1; end
            end
          endcase
        end
      end
    end
    lvl = m_lvl[v];
  endtask

  typedef struct { int v; int lvl; } exp_t;
  exp_t sbq[$];
  bit   sb_en = 0;
  int   dut_lvl[NV];

  always @(negedge m_clock) begin
    exp_t e;
    if (sb_en && env_valid) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("env_voice", 32'(env_voice), 32'(e.v));
        chk($sformatf("env_level_v%0d", e.v), 32'(env_level), 32'(e.lvl));
      end
    end
    if (env_valid && int'(env_voice) < NV) dut_lvl[env_voice] = int'(env_level);
  end

  int lat, first_env;

  task automatic do_tick();
    exp_t e;
    int cnt;
    for (int v = 0; v < NV; v++) begin
      e.v = v;
      model_voice(v, e.lvl);
      sbq.push_back(e);
    end
    @(posedge m_clock); #1 tick = 1'b1;
    @(posedge m_clock); #1 tick = 1'b0;
    cnt = 1; first_env = -1;
    @(negedge m_clock);
    while (!frame_done && cnt < 100) begin
      if (env_valid && first_env < 0) first_env = cnt;
      cnt++;
      @(negedge m_clock);
    end
    lat = cnt;
    if (cnt >= 100) chk("tick_timeout", 32'(cnt), 32'd49);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic press(input logic [NV-1:0] on, input logic [NV-1:0] off);
    @(posedge m_clock); #1 key_on = on; key_off = off;
    @(posedge m_clock); #1 key_on = '0; key_off = '0;
    for (int i = 0; i < NV; i++) begin
      if (on[i])  begin m_pon[i] = 1; m_end[i] = 0; end
      if (off[i]) m_poff[i] = 1;
    end
  endtask

  task automatic write_cfg(input int v, input int ar, input int dr, input int sl, input int sr, input int rr);
    logic [31:0] d;
    d = (32'(ar) << 25) | (32'(dr) << 18) | (32'(sl) << 14) | (32'(sr) << 7) | 32'(rr);
    @(posedge m_clock); #1 cfg_we = 1'b1; cfg_voice = 5'(v); cfg_data = d;
    @(posedge m_clock); #1 cfg_we = 1'b0;
    m_cfg[v] = d;
  endtask

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int fd_cnt, fd_at;
    p_reset = 1'b0; tick = 1'b0; key_on = '0; key_off = '0;
    cfg_we = 1'b0; cfg_voice = '0; cfg_data = '0;
    model_reset();
    for (int i = 0; i < NV; i++) dut_lvl[i] = -1;
    repeat (3) @(posedge m_clock);
    @(negedge m_clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_env_valid", 32'(env_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rom_read", 32'(rom_read), 32'd0);
    chk("rst_env_level", 32'(env_level), 32'd0);
    @(posedge m_clock); #1 p_reset = 1'b1;

    // Reset in the middle of a sweep must abort it cleanly
    @(posedge m_clock); #1 tick = 1'b1;
    @(posedge m_clock); #1 tick = 1'b0;
    repeat (9) @(posedge m_clock);
    @(negedge m_clock);
    chk("busy_mid_sweep", 32'(busy), 32'd1);
    @(posedge m_clock); #1 p_reset = 1'b0;
    @(posedge m_clock);
    @(negedge m_clock);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge m_clock); #1 p_reset = 1'b1;
    fd_cnt = 0;
    repeat (60) begin
      @(negedge m_clock);
      if (frame_done) fd_cnt++;
    end
    chk("rst_no_frame_done", 32'(fd_cnt), 32'd0);
    model_reset();
    sbq.delete();
    sb_en = 1'b1;

    write_cfg(3, 8'h00, 0, 14, 8'h7F, 0);
    write_cfg(5, 8'h04, 0, 0, 0, 0);
    write_cfg(6, 8'h40, 0, 0, 0, 0);
    write_cfg(7, 8'h00, 0, 0, 0, 0);
    press(NV'(1) << 3 | NV'(1) << 5 | NV'(1) << 6 | NV'(1) << 7, NV'(1) << 7);

    do_tick();
    chk("first_env_lat", 32'(first_env), 32'd2);
    chk("frame_lat", 32'(lat), 32'd49);
    chk("v7_keyon_level", 32'(dut_lvl[7]), 32'd0);
    chk("v3_keyon_level", 32'(dut_lvl[3]), 32'd0);

    run_ticks(20);
    chk("v3_attack_20", 32'(dut_lvl[3]), 32'd640);
    chk("v5_half_rate", 32'(dut_lvl[5]), 32'd320);
    chk("v6_zero_rate", 32'(dut_lvl[6]), 32'd0);
    chk("v7_attack_20", 32'(dut_lvl[7]), 32'd640);

    press('0, NV'(1) << 7);
    do_tick();
    chk("v7_release_first", 32'(dut_lvl[7]), 32'd608);
    run_ticks(19);
    chk("v7_release_end", 32'(dut_lvl[7]), 32'd0);
`ifdef SPU_ADSR_ENDX_EN
    chk("v7_voice_end", 32'(voice_end[7]), 32'(m_end[7]));
    chk("v3_voice_end", 32'(voice_end[3]), 32'd0);
`endif
    run_ticks(2);
    chk("v7_off_stays", 32'(dut_lvl[7]), 32'd0);

    run_ticks(1023 - 42);
    chk("v3_attack_1023", 32'(dut_lvl[3]), 32'h7FE0);
    do_tick();
    chk("v3_peak_1024", 32'(dut_lvl[3]), 32'h7FFF);
    do_tick();
    chk("v3_decay_first", 32'(dut_lvl[3]), 32'h7FDF);
    run_ticks(63);
    chk("v3_sustain_clamp", 32'(dut_lvl[3]), 32'h77FF);
    run_ticks(5);
    chk("v3_sustain_hold", 32'(dut_lvl[3]), 32'h77FF);
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Second tick 10 cycles into a sweep
    begin
      exp_t e;
      for (int v = 0; v < NV; v++) begin
        e.v = v;
        model_voice(v, e.lvl);
        sbq.push_back(e);
      end
    end
    @(posedge m_clock); #1 tick = 1'b1;
    @(posedge m_clock); #1 tick = 1'b0;
    fd_cnt = 0; fd_at = -1;
    for (int c = 1; c < 120; c++) begin
      @(negedge m_clock);
      if (frame_done) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = c;
      end
      @(posedge m_clock); #1 tick = (c == 9);
    end
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_fd_count", 32'(fd_cnt), 32'd1);
    chk("overrun_fd_at", 32'(fd_at), 32'd49);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
